// File: rtl/tl_xbar_pkg.sv
// rtl/tl_xbar_pkg.sv - shared crossbar arbiter types and pointer helper
package tl_xbar_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin pointer increment that wraps at n, never into the unused codes above n-1.
    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// rtl/tl_rr_pick.sv - combinational rotating-priority encoder
// Picks the requester nearest at or after ptr (mod N); gnt_idx falls back to ptr when idle.
module tl_rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin : p_pick
        int unsigned w_dist;
        int unsigned w_best;
        w_dist  = 0;
        w_best  = N;
        gnt_idx = ptr;
        any     = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_dist = 32'(j) + 32'(N) - 32'(ptr);
            if (w_dist >= 32'(N)) w_dist = w_dist - 32'(N);
            if (req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                gnt_idx = SEL_W'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_rr_arbiter.sv
// rtl/tl_rr_arbiter.sv - N-to-1 round-robin TileLink arbiter with burst lock
// Optional macro TL_ARB_OUTREG_EN adds a full-throughput output register slice.
module tl_rr_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 64,
    parameter int SEL_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N-1:0]        valid_i,
    output logic [N-1:0]        ready_o,
    input  logic [N*DATA_W-1:0] data_i,
    input  logic [N-1:0]        last_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                last_o,
    output logic [SEL_W-1:0]    sel_o
);
    import tl_xbar_pkg::*;

    arb_state_e        r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [SEL_W-1:0]  r_lock_idx, w_lock_idx_nxt;
    logic [SEL_W-1:0]  w_pick_idx, w_gnt;
    logic              w_pick_any, w_valid, w_last, w_arb_ready, w_fire;
    logic [DATA_W-1:0] w_data;

    tl_rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req     (valid_i),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    assign w_gnt   = (r_state == ARB_LOCKED) ? r_lock_idx : w_pick_idx;
    assign w_valid = (r_state == ARB_LOCKED) ? valid_i[r_lock_idx] : w_pick_any;
    assign w_data  = data_i[w_gnt*DATA_W +: DATA_W];
    assign w_last  = w_valid & last_i[w_gnt];
    assign w_fire  = w_valid & w_arb_ready;

    // Any offered-but-not-taken beat locks, so a late requester cannot swap the payload.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_idx_nxt = r_lock_idx;
        ready_o        = '0;
        if (w_valid) ready_o[w_gnt] = w_arb_ready;
        case (r_state)
            ARB_IDLE: begin
                if (w_valid) begin
                    if (w_fire && w_last) begin
                        w_rr_ptr_nxt = SEL_W'(ptr_inc(32'(w_gnt), N));
                    end else begin
                        w_state_nxt    = ARB_LOCKED;
                        w_lock_idx_nxt = w_gnt;
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_fire && w_last) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = SEL_W'(ptr_inc(32'(r_lock_idx), N));
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

`ifdef TL_ARB_OUTREG_EN
    logic              r_out_valid, r_out_last;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    // Slice refills in the same cycle it drains, keeping one beat per cycle.
    assign w_arb_ready = !r_out_valid || ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_arb_ready) begin
            r_out_valid <= w_valid;
            r_out_last  <= w_last;
            r_out_data  <= w_data;
            r_out_sel   <= w_gnt;
        end
    end

    assign valid_o = r_out_valid;
    assign last_o  = r_out_last;
    assign data_o  = r_out_data;
    assign sel_o   = r_out_sel;
`else
    assign w_arb_ready = ready_i;
    assign valid_o     = w_valid;
    assign last_o      = w_last;
    assign data_o      = w_data;
    assign sel_o       = w_gnt;
`endif

endmodule

// File: tb/tb_tl_rr_arbiter.sv
// tb/tb_tl_rr_arbiter.sv - directed-vector bench for tl_rr_arbiter
module tb_tl_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  valid_i, ready_o, last_i;
    logic [N*DW-1:0] data_i;
    logic          valid_o, ready_i, last_o;
    logic [DW-1:0] data_o;
    logic [SW-1:0] sel_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tl_rr_arbiter #(.N(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o),
        .sel_o   (sel_o)
    );

    function automatic logic [63:0] pdat(input int i);
        return 64'hC0DE_0000_0000_00A0 + 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_k;
        int q2 [3];
        rst_i   = 1'b1;
        valid_i = '0;
        last_i  = '0;
        ready_i = 1'b0;
        for (int i = 0; i < N; i++) data_i[i*DW +: DW] = pdat(i);
        tick;
        tick;
        rst_i = 1'b0;

        @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_last", last_o, 0);
`ifndef TL_ARB_OUTREG_EN
        chk("rst_data", data_o, pdat(0));
`endif
        tick;

`ifdef TL_ARB_OUTREG_EN
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        exp_k   = 0;
        for (int c = 0; c < 24; c++) begin
            ready_i = (c < 8) ? 1'b1 : ((c % 2) == 0);
            @(negedge clk);
            if (c == 0) chk("oreg_lat", valid_o, 0);
            else        chk("oreg_thru", valid_o, 1);
            if (valid_o && ready_i) begin
                chk("oreg_sel", sel_o, exp_k % 4);
                chk("oreg_data", data_o, pdat(exp_k % 4));
                exp_k++;
            end
            tick;
        end
        chk("oreg_beats", exp_k, 15);
`else
        // all four single-beat requesters rotate
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rot_sel", sel_o, c % 4);
            chk("rot_rdy", ready_o, 1 << (c % 4));
            tick;
        end

        // step rr_ptr to 1, then ports 0 and 2 alternate
        valid_i = 4'b0001;
        @(negedge clk);
        chk("pre_sel", sel_o, 0);
        tick;
        valid_i = 4'b0101;
        q2 = '{2, 0, 2};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("alt_sel", sel_o, q2[c]);
            tick;
        end
        valid_i = 4'b0001;
        @(negedge clk);
        chk("wrap_sel", sel_o, 0);
        tick;

        // port 1 four-beat burst while port 2 waits
        valid_i = 4'b0110;
        for (int b = 0; b < 4; b++) begin
            last_i = (b == 3) ? 4'b0110 : 4'b0100;
            @(negedge clk);
            chk("burst_sel", sel_o, 1);
            chk("burst_rdy", ready_o, 4'b0010);
            chk("burst_last", last_o, (b == 3));
            tick;
        end
        valid_i = 4'b0100;
        @(negedge clk);
        chk("after_burst_sel", sel_o, 2);
        chk("after_burst_rdy", ready_o, 4'b0100);
        tick;
        valid_i = 4'b1000;
        last_i  = 4'b1111;
        @(negedge clk);
        chk("p3_sel", sel_o, 3);
        tick;

        // rr_ptr=0: port 3 stalls, port 0 arrives nearer the pointer
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            valid_i = (c == 0) ? 4'b1000 : 4'b1001;
            @(negedge clk);
            chk("stall_sel", sel_o, 3);
            chk("stall_data", data_o, pdat(3));
            chk("stall_valid", valid_o, 1);
            chk("stall_rdy", ready_o, 0);
            tick;
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("stall_fire_sel", sel_o, 3);
        chk("stall_fire_rdy", ready_o, 4'b1000);
        tick;
        valid_i = 4'b0001;
        @(negedge clk);
        chk("post_stall_sel", sel_o, 0);
        tick;

        // reset during beat 2 of a port-1 burst
        valid_i = 4'b0010;
        last_i  = 4'b0000;
        @(negedge clk);
        chk("rb_beat1_sel", sel_o, 1);
        tick;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rb_beat2_sel", sel_o, 1);
        tick;
        rst_i   = 1'b0;
        valid_i = 4'b0011;
        last_i  = 4'b0011;
        @(negedge clk);
        chk("rb_post_sel", sel_o, 0);
        chk("rb_post_rdy", ready_o, 4'b0001);
        tick;

        valid_i = 4'b0000;
        @(negedge clk);
        chk("idle_sel", sel_o, 1);
        chk("idle_valid", valid_o, 0);
        chk("idle_rdy", ready_o, 0);
        tick;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_rr_arbiter.md
Name: tl_rr_arbiter

Overview:
- N-to-1 round-robin arbiter with burst lock for one TileLink channel inside the crossbar.
- Merges N source ports onto one sink port. Pairs with the crossbar's 1-to-N routing demux on the return path.
- Holds the grant until the last beat of a multi-beat message completes. Valid/data never change under backpressure.
- Exports the granted index so the crossbar can tag or route the response.

Parameters:
- N, 4, number of requesting input ports (2..16; non-power-of-2 allowed)
- DATA_W, 64, payload width per port (full channel bundle, opaque)
- SEL_W, 2, width of grant index; must satisfy 2**SEL_W >= N

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- valid_i  input  N  per-port request valid
- ready_o  output  N  per-port ready
- data_i  input  N*DATA_W  per-port payload, port i at [i*DATA_W +: DATA_W]
- last_i  input  N  per-port last-beat flag, qualified by valid_i
- valid_o  output  1  merged valid to sink
- ready_i  input  1  sink ready
- data_o  output  DATA_W  granted payload
- last_o  output  1  granted last-beat flag
- sel_o  output  SEL_W  granted port index

Behaviour:
- One clock; reset is synchronous and active-high, on clk_i / rst_i.
- State: state in {IDLE, LOCKED}, rr_ptr[SEL_W], lock_idx[SEL_W].
- Reset values: state=IDLE, rr_ptr=0, lock_idx=0.
- Outputs after reset with no valid_i: valid_o=0, ready_o=0, sel_o=0, data_o=data of port 0, last_o=0.

IDLE:
- grant = first i with valid_i[i], searching rr_ptr, rr_ptr+1, ... mod N.
- No valid_i → valid_o=0, sel_o=rr_ptr, all ready_o=0.
- Otherwise: valid_o=1, sel_o=grant, data_o/last_o from grant, ready_o[grant]=ready_i, others 0.
- Zero-latency combinational path.

LOCKED:
- grant = lock_idx. valid_o=valid_i[lock_idx]. Other ports' ready_o=0 regardless of their valid.

Handshake (fire) = valid_o && ready_i.

Transitions:
- IDLE, valid_o && !ready_i → LOCKED, lock_idx<=grant. Prevents a newly arriving port nearer rr_ptr from changing the payload under stall.
- IDLE, fire && !last → LOCKED, lock_idx<=grant.
- IDLE, fire && last → stay IDLE, rr_ptr<=grant+1 mod N.
- LOCKED, fire && last → IDLE, rr_ptr<=lock_idx+1 mod N.
- LOCKED, otherwise → hold.

Rules:
- Wrap: rr_ptr=N-1 advances to 0, never to N..2**SEL_W-1.
- Single-beat messages must be presented with last_i=1.
- A locked port dropping valid mid-burst is a protocol violation. The arbiter stays LOCKED and waits; there is no timeout.
- Simultaneous requests: exactly one grant, fairness by rotation. Each of k contending ports is served once per k messages.
- Same-cycle fire-with-last and a new request from another port: the new request is considered next cycle with the updated rr_ptr.
- Reset mid-burst: state→IDLE, rr_ptr→0 next edge, lock dropped. Outputs revert to IDLE combinational behaviour.

Optional Feature:
- Macro TL_ARB_OUTREG_EN.
- Defined:
  - Full-throughput output register slice, adding 1 cycle latency on valid_o/data_o/last_o/sel_o.
  - Internal arbitration "ready" = !slice_full || ready_i.
  - Output register: reset valid=0, sel=0.
  - Back-to-back beats sustain 1/cycle.
  - rr_ptr/lock update on arbitration-side fire, not sink-side.
- Undefined: purely combinational output path as above.

Decomposition:
- Shared package tl_xbar_pkg:
  - arbiter state encoding (ARB_IDLE=1'b0, ARB_LOCKED=1'b1)
  - helper function for mod-N pointer increment
- Sub-module tl_rr_pick:
  - combinational rotating-priority encoder
  - inputs: req[N], ptr[SEL_W]; outputs: gnt_idx[SEL_W], any
  - reused by other crossbar channels

Test Plan (N=4, DATA_W=64):
- Reset, then valid_i=0 → valid_o=0, ready_o=0000, sel_o=0. Then valid_i=4'b1111, all last=1, ready_i=1 for 8 cycles → sel_o sequence 0,1,2,3,0,1,2,3.
- valid_i=4'b0101, rr_ptr=1 → first grant 2, then 0, then 2. Wrap from rr_ptr=3 with only port 0 valid → sel_o=0.
- Port 1 sends a 4-beat burst (last on beat 4) while port 2 is valid throughout → sel_o=1 for all 4 beats, ready_o[2]=0. Port 2 is granted on cycle 5.
- Port 3 valid, ready_i=0 for 3 cycles, port 0 asserts in cycle 2 → sel_o stays 3 and data_o stays stable until fire.
- rst_i asserted during beat 2 of a 4-beat port-1 burst → next cycle state=IDLE, rr_ptr=0. With valid_i=4'b0011, sel_o=0.
- With TL_ARB_OUTREG_EN, 4 ports streaming single-beat messages, ready_i=1 → first valid_o one cycle after valid_i, then 1 beat/cycle. With ready_i toggled 1010…, no beat is lost or duplicated; compare against a scoreboard.
